// File: rtl/door_pkg.sv
// Shared definitions for the door animation controller and its sprite address path.
//   door_state_t : animation FSM states
//   SCREEN_W/H   : visible raster size the sprite is stretched over
//   H_LAST/V_LAST: coordinates of the last visible pixel (end-of-frame point)
package door_pkg;

    typedef enum logic [1:0] {
        OPEN    = 2'd0,
        CLOSING = 2'd1,
        CLOSED  = 2'd2,
        OPENING = 2'd3
    } door_state_t;

    localparam logic [9:0] SCREEN_W = 10'd640;
    localparam logic [9:0] SCREEN_H = 10'd480;
    localparam logic [9:0] H_LAST   = 10'd639;
    localparam logic [9:0] V_LAST   = 10'd479;

endpackage

// File: rtl/sprite_addr_gen.sv
// Registered stretch-mapping address generator for a full-screen sprite.
// Maps the 640x480 visible raster onto a SPRITE_W x SPRITE_H texel grid and
// adds the result to the base address of the selected frame.
// Ports:
//   vga_clk     : pixel clock
//   reset       : asynchronous, active-high reset
//   DrawX/DrawY : current pixel column/row
//   frame_base  : ROM word address of texel (0,0) of the current frame
//   rom_address : registered ROM read address, one vga_clk after DrawX/DrawY
module sprite_addr_gen #(
    parameter int SPRITE_W = 35,
    parameter int SPRITE_H = 35,
    parameter int ADDR_W   = 13
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [ADDR_W-1:0] frame_base,
    output logic [ADDR_W-1:0] rom_address
);
    import door_pkg::*;

    logic [31:0] x_prod;
    logic [31:0] y_prod;
    logic [31:0] texel_col;
    logic [31:0] texel_row;
    logic [31:0] offset;
    logic        on_screen;

    // Divisors are constants, so these reduce to fixed multiply/shift logic.
    always_comb begin
        x_prod    = 32'(DrawX) * 32'(SPRITE_W);
        y_prod    = 32'(DrawY) * 32'(SPRITE_H);
        texel_col = x_prod / 32'(SCREEN_W);
        texel_row = y_prod / 32'(SCREEN_H);
        offset    = texel_col + texel_row * 32'(SPRITE_W);
        on_screen = (DrawX < SCREEN_W) && (DrawY < SCREEN_H);
    end

    // Off-screen pixels park on the frame base; the blanked output ignores them.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_address <= '0;
        end else if (on_screen) begin
            rom_address <= frame_base + ADDR_W'(offset);
        end else begin
            rom_address <= frame_base;
        end
    end

endmodule

// File: rtl/door_anim_ctrl.sv
// Door animation sequencer for the full-screen door sprite ROM.
// Steps through the stored frames at end-of-frame only (no tearing) and
// produces the per-pixel ROM read address.
// Ports:
//   vga_clk, reset : pixel clock, asynchronous active-high reset
//   DrawX, DrawY   : current pixel position
//   door_req       : 1 = player wants the door closed
//   power_out      : 1 = force the door open
//   rom_address    : registered sprite ROM read address
//   frame_idx      : animation frame currently displayed (0 open .. NUM_FRAMES-1 closed)
//   door_closed    : high only while CLOSED
//   busy           : high while CLOSING or OPENING
//
// state   | meaning
// --------+---------------------------------------------------------
// OPEN    | frame 0 shown, waiting for a close request
// CLOSING | advancing toward the closed frame every FRAME_HOLD ticks
// CLOSED  | last frame shown, waiting for the request to drop
// OPENING | stepping back toward frame 0 every FRAME_HOLD ticks
module door_anim_ctrl #(
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_HOLD  = 6,
    parameter int SPRITE_W    = 35,
    parameter int SPRITE_H    = 35,
    parameter int FRAME_WORDS = SPRITE_W * SPRITE_H,
    parameter int ADDR_W      = 13
) (
    input  logic                          vga_clk,
    input  logic                          reset,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic                          door_req,
    input  logic                          power_out,
    output logic [ADDR_W-1:0]             rom_address,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
    output logic                          door_closed,
    output logic                          busy
);
    import door_pkg::*;

    localparam int IDX_W  = $clog2(NUM_FRAMES);
    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_FRAMES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(FRAME_WORDS);

    door_state_t       state;
    door_state_t       state_nxt;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [ADDR_W-1:0] frame_base;
    logic [ADDR_W-1:0] base_nxt;
    logic              frame_tick;
    logic              req_close;

    assign frame_tick = (DrawX == H_LAST) && (DrawY == V_LAST);
    assign req_close  = door_req & ~power_out;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state       <= OPEN;
            hold        <= '0;
            frame_idx   <= '0;
            frame_base  <= '0;
            door_closed <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold        <= hold_nxt;
            frame_idx   <= idx_nxt;
            frame_base  <= base_nxt;
            door_closed <= (state_nxt == CLOSED);
            busy        <= (state_nxt == CLOSING) || (state_nxt == OPENING);
        end
    end

    // frame_base tracks frame_idx by adding/subtracting one frame's worth of
    // words, so no multiplier is needed.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        idx_nxt   = frame_idx;
        base_nxt  = frame_base;

        if (frame_tick) begin
            unique case (state)
                OPEN: begin
                    if (req_close) begin
                        state_nxt = CLOSING;
                        hold_nxt  = '0;
                    end
                end

                CLOSING: begin
                    if (!req_close) begin
                        state_nxt = OPENING;
                        hold_nxt  = '0;
                    end else if (hold == HOLD_LAST) begin
                        hold_nxt = '0;
                        if (frame_idx != IDX_LAST) begin
                            idx_nxt  = frame_idx + 1'b1;
                            base_nxt = frame_base + BASE_STEP;
                        end
                        if (idx_nxt == IDX_LAST) begin
                            state_nxt = CLOSED;
                        end
                    end else begin
                        hold_nxt = hold + 1'b1;
                    end
                end

                CLOSED: begin
                    if (!req_close) begin
                        state_nxt = OPENING;
                        hold_nxt  = '0;
                    end
                end

                OPENING: begin
                    if (req_close) begin
                        state_nxt = CLOSING;
                        hold_nxt  = '0;
                    end else if (hold == HOLD_LAST) begin
                        hold_nxt = '0;
                        if (frame_idx != '0) begin
                            idx_nxt  = frame_idx - 1'b1;
                            base_nxt = frame_base - BASE_STEP;
                        end
                        if (idx_nxt == '0) begin
                            state_nxt = OPEN;
                        end
                    end else begin
                        hold_nxt = hold + 1'b1;
                    end
                end

                default: begin
                    state_nxt = OPEN;
                    hold_nxt  = '0;
                    idx_nxt   = '0;
                    base_nxt  = '0;
                end
            endcase
        end
    end

    sprite_addr_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_base  (frame_base),
        .rom_address (rom_address)
    );

endmodule

// File: tb/tb_door_anim_ctrl.sv
module tb_door_anim_ctrl;

    logic        vga_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [9:0]  DrawX   = 10'd0;
    logic [9:0]  DrawY   = 10'd0;
    logic        door_req  = 1'b0;
    logic        power_out = 1'b0;
    logic [12:0] rom_address;
    logic [1:0]  frame_idx;
    logic        door_closed;
    logic        busy;

    door_anim_ctrl dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .door_req    (door_req),
        .power_out   (power_out),
        .rom_address (rom_address),
        .frame_idx   (frame_idx),
        .door_closed (door_closed),
        .busy        (busy)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          due;
        bit          chk_state;
        logic [1:0]  idx;
        logic        closed;
        logic        busy;
        bit          chk_addr;
        logic [12:0] addr;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic exp_state(input string nm, input int idx, input bit cl, input bit bz);
        exp_t e;
        e.name = nm; e.due = cyc; e.chk_state = 1'b1;
        e.idx = 2'(idx); e.closed = cl; e.busy = bz;
        e.chk_addr = 1'b0; e.addr = '0;
        q.push_back(e);
    endtask

    task automatic exp_addr(input string nm, input int dly, input int addr);
        exp_t e;
        e.name = nm; e.due = cyc + dly; e.chk_state = 1'b0;
        e.idx = '0; e.closed = 1'b0; e.busy = 1'b0;
        e.chk_addr = 1'b1; e.addr = 13'(addr);
        q.push_back(e);
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge vga_clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.due != cyc) begin
                n_checks++; n_fail++;
                $display("FAIL %s: checked at cycle %0d, was due at %0d", e.name, cyc, e.due);
            end
            if (e.chk_state) begin
                n_checks++;
                if (frame_idx !== e.idx) begin
                    n_fail++;
                    $display("FAIL %s: frame_idx got %0d expected %0d", e.name, frame_idx, e.idx);
                end
                n_checks++;
                if (door_closed !== e.closed) begin
                    n_fail++;
                    $display("FAIL %s: door_closed got %b expected %b", e.name, door_closed, e.closed);
                end
                n_checks++;
                if (busy !== e.busy) begin
                    n_fail++;
                    $display("FAIL %s: busy got %b expected %b", e.name, busy, e.busy);
                end
            end
            if (e.chk_addr) begin
                n_checks++;
                if (rom_address !== e.addr) begin
                    n_fail++;
                    $display("FAIL %s: rom_address got %0d expected %0d", e.name, rom_address, e.addr);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    // One end-of-frame strobe, then a couple of ordinary pixels. Returns in a
    // cycle where the post-tick state is visible.
    task automatic do_tick();
        DrawX = 10'd639; DrawY = 10'd479;
        idle(1);
        DrawX = 10'd10;  DrawY = 10'd10;
        idle(2);
    endtask

    task automatic addr_probe(input string nm, input int x, input int y, input int addr);
        DrawX = 10'(x); DrawY = 10'(y);
        exp_addr(nm, 1, addr);
        idle(1);
        DrawX = 10'd10; DrawY = 10'd10;
        idle(1);
    endtask

    initial begin
        idle(1);
        exp_state("reset", 0, 0, 0);
        exp_addr("reset_addr", 0, 0);
        idle(1);
        reset = 1'b0;
        idle(2);

        // OPEN, frame 0: stretch mapping and a harmless tick with no request
        addr_probe("addr_last_px", 639, 479, 1224);
        exp_state("open_after_tick", 0, 0, 0);
        addr_probe("addr_center_f0", 320, 240, 612);
        addr_probe("addr_origin_f0", 0, 0, 0);

        // Full close: steps at ticks 7, 13, 19
        door_req = 1'b1;
        for (int t = 1; t <= 19; t++) begin
            int ei;
            ei = (t >= 19) ? 3 : (t >= 13) ? 2 : (t >= 7) ? 1 : 0;
            do_tick();
            exp_state($sformatf("close_t%0d", t), ei, (t >= 19), (t < 19));
        end

        // CLOSED, frame 3 (base 3675)
        addr_probe("addr_center_f3", 320, 240, 4287);
        addr_probe("addr_offscreen_f3", 700, 10, 3675);
        addr_probe("addr_lastrow_f3", 0, 479, 4865);

        // Request glitch between ticks must not disturb anything
        door_req = 1'b0;
        idle(1);
        door_req = 1'b1;
        idle(1);
        exp_state("glitch_no_change", 3, 1, 0);
        do_tick();
        exp_state("closed_hold", 3, 1, 0);

        // power_out forces opening even with door_req held
        power_out = 1'b1;
        do_tick();
        exp_state("pwr_opening", 3, 0, 1);
        for (int t = 1; t <= 5; t++) do_tick();
        exp_state("opening_hold", 3, 0, 1);
        do_tick();
        exp_state("opening_step2", 2, 0, 1);

        // Reverse to CLOSING at frame 2, then drop the request at frame 2
        power_out = 1'b0;
        do_tick();
        exp_state("rev_closing_f2", 2, 0, 1);
        door_req = 1'b0;
        do_tick();
        exp_state("rev_opening_f2", 2, 0, 1);
        addr_probe("addr_center_f2", 320, 240, 3062);
        for (int t = 1; t <= 5; t++) do_tick();
        exp_state("rev_hold_f2", 2, 0, 1);
        do_tick();
        exp_state("rev_step_f1", 1, 0, 1);
        for (int t = 1; t <= 6; t++) do_tick();
        exp_state("rev_open_done", 0, 0, 0);
        addr_probe("addr_center_back_f0", 320, 240, 612);

        // Reset in the middle of CLOSING at frame 2
        door_req = 1'b1;
        for (int t = 1; t <= 13; t++) do_tick();
        exp_state("close_to_f2", 2, 0, 1);
        do_tick();
        reset = 1'b1;
        exp_state("rst_mid", 0, 0, 0);
        exp_addr("rst_mid_addr", 0, 0);
        idle(1);
        reset = 1'b0;
        idle(1);
        exp_state("post_rst", 0, 0, 0);
        do_tick();
        exp_state("post_rst_tick_open", 0, 0, 1);

        idle(3);
        if (q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
